// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory round-robin arbiter.
// The optional MEM_ARB_LOCK_EN build uses arb_state_e for its lock FSM.
package mem_arb_pkg;

  localparam int unsigned MAX_REQ = 8;

  typedef enum logic {
    FREE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // First asserted request at or after ptr, wrapping at num; ptr must be < num.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [3:0]         num,
                                         input logic [2:0]         ptr);
    logic [2:0] pick;
    logic       found;
    logic [3:0] cand;
    pick  = 3'd0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      cand = {1'b0, ptr} + 4'(k);
      if (cand >= num) begin
        cand = cand - num;
      end else begin
        cand = cand;
      end
      if (!found && (4'(k) < num) && req[cand[2:0]]) begin
        pick  = cand[2:0];
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// Combinational rotate-and-priority-encode: picks the first request at or
// after ptr (wrapping) and returns it both one-hot and as an index.
module rr_prio_enc
  import mem_arb_pkg::*;
#(
  parameter  int unsigned N  = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [MAX_REQ-1:0] req_pad;

  assign req_pad = MAX_REQ'(req);
  assign idx     = IW'(rr_pick(req_pad, 4'(N), 3'(ptr)));

  // One-hot grant, empty when nothing requests.
  always_comb begin
    gnt = {N{1'b0}};
    if (|req) begin
      gnt[idx] = 1'b1;
    end else begin
      gnt = {N{1'b0}};
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port 1-cycle SRAM among NUM_REQ requesters.
// Define MEM_ARB_LOCK_EN to add lock_i and owner locking for atomic sequences.
module mem_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 2,
  parameter  int unsigned MEM_AW  = 16,
  parameter  int unsigned MEM_DW  = 32,
  localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NUM_REQ-1:0]          req_i,
  input  logic [NUM_REQ-1:0]          we_i,
  input  logic [NUM_REQ*MEM_AW-1:0]   addr_i,
  input  logic [NUM_REQ*MEM_DW-1:0]   wdata_i,
  input  logic [NUM_REQ*MEM_DW/8-1:0] be_i,
`ifdef MEM_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]          lock_i,
`endif
  output logic [NUM_REQ-1:0]          gnt_o,
  output logic [NUM_REQ-1:0]          rvalid_o,
  output logic [MEM_DW-1:0]           rdata_o,
  output logic                        mem_req_o,
  output logic                        mem_we_o,
  output logic [MEM_AW-1:0]           mem_addr_o,
  output logic [MEM_DW-1:0]           mem_wdata_o,
  output logic [MEM_DW/8-1:0]         mem_be_o,
  input  logic [MEM_DW-1:0]           mem_rdata_i
);

  localparam int unsigned BE_W = MEM_DW / 8;

  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] win_gnt;
  logic [IDX_W-1:0]   win_idx;
  logic               any_gnt;
  logic               locked;
  logic               rd_gnt;
  logic [IDX_W-1:0]   ptr_nxt;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   rd_idx_q;
  logic               rd_pend_q;

`ifdef MEM_ARB_LOCK_EN
  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;

  // Lock holds only while the owner keeps lock_i high; the release cycle arbitrates freely.
  assign locked  = (state_q == LOCKED) && lock_i[owner_q];
  assign arb_req = locked ? (req_i & ({{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q)) : req_i;

  // Lock FSM next state.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      FREE, LOCKED: begin
        if (locked) begin
          state_d = LOCKED;
        end else if (any_gnt && lock_i[win_idx]) begin
          state_d = LOCKED;
          owner_d = win_idx;
        end else begin
          state_d = FREE;
        end
      end
      default: begin
        state_d = FREE;
        owner_d = {IDX_W{1'b0}};
      end
    endcase
  end

  // Lock FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FREE;
      owner_q <= {IDX_W{1'b0}};
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end
`else
  assign locked  = 1'b0;
  assign arb_req = req_i;
`endif

  rr_prio_enc #(.N(NUM_REQ)) u_prio_enc (
    .req (arb_req),
    .ptr (rr_ptr_q),
    .gnt (win_gnt),
    .idx (win_idx)
  );

  assign any_gnt = |arb_req;
  assign rd_gnt  = any_gnt && !we_i[win_idx];
  assign ptr_nxt = (win_idx == IDX_W'(NUM_REQ - 1)) ? {IDX_W{1'b0}} : win_idx + IDX_W'(1);
  assign rdata_o = mem_rdata_i;

  // Grant and SRAM-side mux; everything idles to zero without a request.
  always_comb begin
    gnt_o       = {NUM_REQ{1'b0}};
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = {MEM_AW{1'b0}};
    mem_wdata_o = {MEM_DW{1'b0}};
    mem_be_o    = {BE_W{1'b0}};
    if (any_gnt) begin
      gnt_o       = win_gnt;
      mem_req_o   = 1'b1;
      mem_we_o    = we_i[win_idx];
      mem_addr_o  = addr_i[win_idx*MEM_AW +: MEM_AW];
      mem_wdata_o = wdata_i[win_idx*MEM_DW +: MEM_DW];
      if (we_i[win_idx]) begin
        mem_be_o = be_i[win_idx*BE_W +: BE_W];
      end else begin
        mem_be_o = {BE_W{1'b1}};
      end
    end else begin
      gnt_o     = {NUM_REQ{1'b0}};
      mem_req_o = 1'b0;
    end
  end

  // Round-robin pointer and pending-read tracking.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q  <= {IDX_W{1'b0}};
      rd_idx_q  <= {IDX_W{1'b0}};
      rd_pend_q <= 1'b0;
    end else begin
      if (any_gnt && !locked) begin
        rr_ptr_q <= ptr_nxt;
      end
      if (rd_gnt) begin
        rd_idx_q <= win_idx;
      end
      rd_pend_q <= rd_gnt;
    end
  end

  // Route the read return to the requester that issued it.
  always_comb begin
    rvalid_o = {NUM_REQ{1'b0}};
    if (rd_pend_q) begin
      rvalid_o[rd_idx_q] = 1'b1;
    end else begin
      rvalid_o = {NUM_REQ{1'b0}};
    end
  end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Self-checking bench for mem_rr_arbiter (NUM_REQ=3) with a transaction-level
// reference model: round-robin winner search, word memory and expected read returns.
module tb_mem_rr_arbiter;

  localparam int N  = 3;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic              clk = 1'b0;
  logic              rst_ni;
  logic [N-1:0]      req_i, we_i;
  logic [N*AW-1:0]   addr_i;
  logic [N*DW-1:0]   wdata_i;
  logic [N*BW-1:0]   be_i;
  logic [N-1:0]      gnt_o, rvalid_o;
  logic [DW-1:0]     rdata_o;
  logic              mem_req_o, mem_we_o;
  logic [AW-1:0]     mem_addr_o;
  logic [DW-1:0]     mem_wdata_o;
  logic [BW-1:0]     mem_be_o;
  logic [DW-1:0]     mem_rdata_i;

  always #5 clk = ~clk;

  mem_rr_arbiter #(.NUM_REQ(N), .MEM_AW(AW), .MEM_DW(DW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i)
  );

  function automatic logic [31:0] init_val(input int i);
    return {8'hA5, 8'(i), 16'(i * 37 + 5)};
  endfunction

  // SRAM model: 64 words indexed by the low address bits, loaded while in reset.
  logic [31:0] sram [0:63];
  always @(posedge clk) begin
    if (!rst_ni) begin
      for (int i = 0; i < 64; i++) sram[i] <= init_val(i);
      mem_rdata_i <= 32'h0;
    end else if (mem_req_o && mem_we_o) begin
      for (int b = 0; b < BW; b++)
        if (mem_be_o[b]) sram[mem_addr_o[5:0]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
    end else if (mem_req_o) begin
      mem_rdata_i <= sram[mem_addr_o[5:0]];
    end
  end

  // Reference model state
  int          n_cmp = 0;
  int          n_err = 0;
  int          ptr_m;
  logic [N-1:0] exp_rv;
  logic [31:0] exp_rdata;
  logic [31:0] ref_mem [0:63];
  logic        t_req   [N];
  logic        t_we    [N];
  logic [15:0] t_addr  [N];
  logic [31:0] t_wdata [N];
  logic [3:0]  t_be    [N];
  logic [N-1:0] last_gnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick_ref(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic set_tr(input int i, input logic we, input logic [15:0] a,
                        input logic [31:0] d, input logic [3:0] be);
    t_req[i] = 1'b1; t_we[i] = we; t_addr[i] = a; t_wdata[i] = d; t_be[i] = be;
  endtask

  task automatic rand_tr(input int i);
    set_tr(i, 1'($urandom_range(0, 1)), 16'($urandom), $urandom, 4'($urandom));
  endtask

  task automatic reset_model();
    ptr_m  = 0;
    exp_rv = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    for (int i = 0; i < N; i++) t_req[i] = 1'b0;
  endtask

  // One clock: drive requests, check at negedge, advance the model, return at posedge+1.
  task automatic cycle();
    logic [N-1:0] r;
    int w;
    for (int i = 0; i < N; i++) begin
      req_i[i] = t_req[i];
      we_i[i]  = t_we[i];
      addr_i[i*AW +: AW]  = t_addr[i];
      wdata_i[i*DW +: DW] = t_wdata[i];
      be_i[i*BW +: BW]    = t_be[i];
      r[i] = t_req[i];
    end
    @(negedge clk);
    w = pick_ref(r, ptr_m);
    last_gnt = gnt_o;
    chk("gnt", gnt_o, (w >= 0) ? (64'd1 << w) : 64'd0);
    chk("mem_req", mem_req_o, (w >= 0) ? 64'd1 : 64'd0);
    chk("rvalid", rvalid_o, exp_rv);
    if (exp_rv != '0) chk("rdata", rdata_o, exp_rdata);
    if (w >= 0) begin
      chk("mem_we", mem_we_o, t_we[w]);
      chk("mem_addr", mem_addr_o, t_addr[w]);
      chk("mem_wdata", mem_wdata_o, t_wdata[w]);
      chk("mem_be", mem_be_o, t_we[w] ? t_be[w] : 4'hF);
      ptr_m = (w + 1) % N;
      if (t_we[w]) begin
        for (int b = 0; b < 4; b++)
          if (t_be[w][b]) ref_mem[t_addr[w][5:0]][8*b +: 8] = t_wdata[w][8*b +: 8];
        exp_rv = '0;
      end else begin
        exp_rv    = N'(1) << w;
        exp_rdata = ref_mem[t_addr[w][5:0]];
      end
      t_req[w] = 1'b0;
    end else begin
      chk("idle_we", mem_we_o, 64'd0);
      chk("idle_addr", mem_addr_o, 64'd0);
      chk("idle_wdata", mem_wdata_o, 64'd0);
      chk("idle_be", mem_be_o, 64'd0);
      exp_rv = '0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int budget;
    budget = 20;
    while ((t_req[0] || t_req[1] || t_req[2]) && budget > 0) begin
      cycle();
      budget--;
    end
    if (budget == 0) begin
      n_err++;
      $error("FAIL drain_timeout: observed pending requests expected none");
    end
    cycle();
  endtask

  initial begin
    rst_ni  = 1'b0;
    req_i   = '0; we_i = '0; addr_i = '0; wdata_i = '0; be_i = '0;
    for (int i = 0; i < N; i++) begin
      t_we[i] = 1'b0; t_addr[i] = 16'h0; t_wdata[i] = 32'h0; t_be[i] = 4'h0;
    end
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rvalid", rvalid_o, 64'd0);
    chk("rst_gnt", gnt_o, 64'd0);
    chk("rst_mem_req", mem_req_o, 64'd0);
    chk("rst_mem_be", mem_be_o, 64'd0);
    rst_ni = 1'b1;

    // Single requester 0: two consecutive reads
    set_tr(0, 1'b0, 16'h0010, 32'h0, 4'h0);
    cycle();
    chk("single_gnt0", last_gnt, 64'h1);
    set_tr(0, 1'b0, 16'h0014, 32'h0, 4'h0);
    cycle();
    chk("single_gnt1", last_gnt, 64'h1);
    cycle();
    cycle();

    // Two requesters reading continuously
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < 2; i++)
        if (!t_req[i]) set_tr(i, 1'b0, 16'($urandom_range(0, 63)), 32'h0, 4'h0);
      cycle();
    end
    drain();

    // Requester 1 partial write while requester 0 reads the same word, then read back
    set_tr(1, 1'b1, 16'h0020, 32'hDEADBEEF, 4'b0011);
    set_tr(0, 1'b0, 16'h0020, 32'h0, 4'h0);
    drain();
    set_tr(2, 1'b0, 16'h0020, 32'h0, 4'h0);
    cycle();
    cycle();
    chk("merged_word", ref_mem[32], {init_val(32)[31:16], 16'hBEEF});

    // Pointer at 2 with all three requesting: order 2, 0, 1, 2
    set_tr(1, 1'b0, 16'h0001, 32'h0, 4'h0);
    cycle();
    for (int i = 0; i < N; i++) set_tr(i, 1'b0, 16'(i + 4), 32'h0, 4'h0);
    cycle();
    chk("wrap_order0", last_gnt, 64'h4);
    set_tr(2, 1'b0, 16'h0007, 32'h0, 4'h0);
    cycle();
    chk("wrap_order1", last_gnt, 64'h1);
    set_tr(0, 1'b0, 16'h0008, 32'h0, 4'h0);
    cycle();
    chk("wrap_order2", last_gnt, 64'h2);
    set_tr(1, 1'b0, 16'h0009, 32'h0, 4'h0);
    cycle();
    chk("wrap_order3", last_gnt, 64'h4);
    drain();

    // Reset the cycle after a granted read
    set_tr(0, 1'b0, 16'h0003, 32'h0, 4'h0);
    cycle();
    chk("rv_before_rst", rvalid_o, 64'h1);
    rst_ni = 1'b0;
    #1;
    chk("rv_async_rst", rvalid_o, 64'd0);
    reset_model();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    cycle();
    cycle();

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!t_req[i] && ($urandom_range(0, 99) < 55)) rand_tr(i);
      cycle();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
